// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver (16x oversampling, 3-sample majority vote) feeding a show-ahead FIFO; ports CLK/RESET, RX in, rd_data/rd_valid/rd_en/count FIFO read side, sticky frame_err/overrun/parity_err cleared by clear_err; define UART_RX_PARITY_EN for an even-parity bit after the data bits.
module uart_rx_buf #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                RX,
  output logic [7:0]                          rd_data,
  output logic                                rd_valid,
  input  logic                                rd_en,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                frame_err,
  output logic                                overrun,
  output logic                                parity_err,
  input  logic                                clear_err
);
  localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int TW = $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [TW-1:0] tcnt;
  logic [3:0] sidx;
  logic [2:0] bcnt, smp;
  logic [7:0] shreg;
  logic tick, ev, ev9, vote, par_bad, push, push_set, frame_set, par_set, idle_hold;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic pop, full, wr;
  assign tick = tcnt == TW'(DIV - 1);
  assign ev = tick && sidx == 4'd15;
  assign ev9 = tick && sidx == 4'd9;
  assign idle_hold = state == IDLE || state == WAIT_HIGH;
  assign vote = sidx == 4'd9 ? (smp[2] & smp[1]) | (smp[2] & rx_s) | (smp[1] & rx_s)
                             : (smp[2] & smp[1]) | (smp[2] & smp[0]) | (smp[1] & smp[0]);
  always_ff @(posedge CLK) begin
    rx_m <= RESET ? 1'b1 : RX;
    rx_s <= RESET ? 1'b1 : rx_m;
  end
  always_ff @(posedge CLK)
    state <= RESET ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (!rx_s) state_n = START;
      START:     if (ev) state_n = vote ? IDLE : DATA;
      DATA:      if (ev && bcnt == 3'd7) state_n = AFTER_DATA;
      PARITY:    if (ev) state_n = STOP;
      STOP:      if (ev9) state_n = vote ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    push_set = state == STOP && ev9 && vote && !par_bad;
    frame_set = state == STOP && ev9 && !vote;
`ifdef UART_RX_PARITY_EN
    par_set = state == PARITY && ev && (vote != ^shreg);
`else
    par_set = 1'b0;
`endif
  end
  always_ff @(posedge CLK) begin
    if (RESET || idle_hold) begin
      tcnt <= '0;
      sidx <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + TW'(1);
      sidx <= tick ? sidx + 4'd1 : sidx;
    end
    if (tick && sidx >= 4'd7 && sidx <= 4'd9) smp <= {rx_s, smp[2:1]};
    if (state == DATA && ev) shreg <= {vote, shreg[7:1]};
    bcnt <= state == IDLE ? 3'd0 : (state == DATA && ev) ? bcnt + 3'd1 : bcnt;
    par_bad <= (RESET || state == IDLE) ? 1'b0 : par_bad | par_set;
    push <= !RESET && push_set;
  end
  assign full = count == CW'(FIFO_DEPTH);
  assign pop = rd_en && rd_valid;
  assign wr = push && (!full || pop);
  assign rd_valid = count != '0;
  assign rd_data = rd_valid ? mem[rp] : 8'h00;
  always_ff @(posedge CLK)
    if (wr) mem[wp] <= shreg;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      wp <= wr ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + CW'(wr) - CW'(pop);
      frame_err <= frame_set ? 1'b1 : clear_err ? 1'b0 : frame_err;
      overrun <= (push && full && !pop) ? 1'b1 : clear_err ? 1'b0 : overrun;
      parity_err <= par_set ? 1'b1 : clear_err ? 1'b0 : parity_err;
    end
  end
endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: directed scoreboard bench for uart_rx_buf at 160 clocks per bit with a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx_buf;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0, clear_err = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, frame_err, overrun, parity_err;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;
  logic [7:0] q[$];
  logic exp_ovr = 1'b0;
  bit hit;
  uart_rx_buf #(.CLK_HZ(1600000), .BAUD(10000), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RESET(rst), .RX(rx), .rd_data(rd_data), .rd_valid(rd_valid), .rd_en(rd_en),
    .count(count), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .clear_err(clear_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input logic par_ok);
    rx = 1'b0;
    cyc(160);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(160);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^d ^ ~par_ok;
    cyc(160);
`endif
    rx = stop;
    cyc(160);
  endtask
  task automatic tx_good(input logic [7:0] d);
    send(d, 1'b1, 1'b1);
    rx = 1'b1;
    cyc(40);
    if (q.size() == 4) exp_ovr = 1'b1;
    else q.push_back(d);
  endtask
  task automatic rd(input string tag);
    logic [7:0] e;
    e = q.pop_front();
    chk({tag, "_valid"}, rd_valid, 1);
    chk(tag, rd_data, e);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask
  initial begin
    cyc(4);
    rst = 1'b0;
    cyc(1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_perr", parity_err, 0);
    tx_good(8'h55);
    chk("b55_count", count, q.size());
    chk("b55_ferr", frame_err, 0);
    rd("b55");
    chk("b55_empty", rd_valid, 0);
    chk("b55_cnt0", count, 0);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    chk("empty_pop_cnt", count, 0);
    rx = 1'b0;
    cyc(40);
    rx = 1'b1;
    cyc(300);
    chk("glitch_count", count, 0);
    chk("glitch_ferr", frame_err, 0);
    send(8'hA3, 1'b0, 1'b1);
    cyc(480);
    rx = 1'b1;
    cyc(200);
    chk("ferr_set", frame_err, 1);
    chk("ferr_count", count, 0);
    tx_good(8'h3C);
    chk("b3c_count", count, q.size());
    chk("b3c_data", rd_data, q[0]);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    chk("ferr_clr", frame_err, 0);
    rd("b3c");
    for (int i = 1; i <= 5; i++) tx_good(8'(i));
    chk("ovr_count", count, 4);
    chk("ovr_flag", overrun, exp_ovr);
    for (int i = 0; i < 4; i++) rd($sformatf("ovr_rd%0d", i));
    chk("ovr_empty", count, 0);
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_clr", overrun, 0);
    for (int i = 1; i <= 4; i++) tx_good(8'(i));
    hit = 1'b0;
    fork
      send(8'h06, 1'b1, 1'b1);
      for (int i = 0; i < 3000 && !hit; i++) begin
        cyc(1);
        if (dut.push) begin
          rd_en = 1'b1;
          cyc(1);
          rd_en = 1'b0;
          hit = 1'b1;
        end
      end
    join
    rx = 1'b1;
    cyc(40);
    chk("bnd_push_seen", hit, 1);
    void'(q.pop_front());
    q.push_back(8'h06);
    chk("bnd_count", count, 4);
    chk("bnd_ovr", overrun, 0);
    for (int i = 0; i < 4; i++) rd($sformatf("bnd_rd%0d", i));
    chk("bnd_empty", rd_valid, 0);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    cyc(40);
    chk("par_err", parity_err, 1);
    chk("par_nopush", count, 0);
    tx_good(8'h07);
    rd("par_ok");
`else
    chk("par_tied", parity_err, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_buf.md
Name: uart_rx_buf

Overview:
- UART receive front-end for the serial console path: 8N1 receiver with 16x oversampling and a show-ahead receive FIFO.
- Takes the raw UART_RXD pin and turns it into a byte stream that the top level or command logic drains with a read strobe.
- It is the receive-side counterpart to the byte transmitter already driving UART_TXD. It runs on the same 25 MHz system clock.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 16, receive FIFO entries; must be a power of 2, at least 2.
- DIV (localparam), (CLK_HZ + BAUD*8)/(BAUD*16), clocks per oversample tick; must be at least 2.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- RX  in  1  asynchronous serial input; idles high.
- rd_data  out  8  byte at the FIFO head; valid only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- rd_en  in  1  pop strobe; ignored when rd_valid=0.
- count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- frame_err  out  1  sticky flag: a stop bit was sampled low.
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- parity_err  out  1  sticky flag for parity errors; see Optional Feature.
- clear_err  in  1  clears all sticky error flags.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - Ports are named CLK and RESET.
  - RESET=1 has these effects on the next edge:
    - state goes to IDLE;
    - FIFO is emptied: rd_valid=0, count=0, rd_data=8'h00;
    - all error flags go to 0;
    - both synchronizer flops go to 1.
  - Reset mid-frame aborts the frame with no push and no error.
- RX input:
  - Two-flop synchronizer (rx_s) feeds the receiver.
  - A 3-sample majority vote over tick indices 7, 8 and 9 of each bit gives the bit value.
- Tick generation:
  - A tick counter runs 0..DIV-1 and pulses tick when it equals DIV-1.
  - A 4-bit sample index counts ticks within a bit.
- State machine:
  - IDLE: both counters are held at 0. When rx_s=0, go to START.
  - START: at sample index 15, evaluate the majority vote.
    - Vote = 1: false start. Return to IDLE with no error.
    - Vote = 0: go to DATA.
  - DATA: 8 bits, LSB first, shifted in at sample index 15 of each bit. After bit 7, go to STOP (or PARITY if enabled).
  - STOP: at sample index 9, the voted value is known.
    - Value 1: push the byte, then go to IDLE.
    - Value 0: set frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering.
- Return to IDLE mid stop bit is intentional: it allows resync on back-to-back frames.
- Latency: the push happens on the edge after the stop-bit index-9 tick. rd_valid rises 1 cycle later.
- FIFO:
  - Show-ahead: rd_data always shows the head entry.
  - rd_en with rd_valid=1 pops; the next entry (or 8'h00 if now empty) appears on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push while full and no pop: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while count=1: rd_valid stays 1 and the new byte becomes the head.
- Error flags: set on event and cleared by clear_err. If a set and a clear happen in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, 16 ticks, sampled like a data bit.
  - Even parity over the 8 data bits.
  - On mismatch: parity_err is set, the stop bit is still checked, and the byte is discarded.
- Undefined:
  - Frame is 8N1.
  - parity_err is tied to 0.

Test Plan:
- Common bench settings: CLK_HZ=1600000, BAUD=10000, so DIV=10 and 160 clocks per bit. FIFO_DEPTH=4.
- Single byte: send 0x55 8N1 → rd_valid=1, rd_data=0x55, count=1, no errors. Pulse rd_en → rd_valid=0, count=0.
- Glitch: drive RX low for 40 clocks then high → no push, frame_err=0, state returns to IDLE.
- Framing error: send 0xA3 with the stop bit low, then hold RX low for 3 bit times, then high → frame_err=1, count=0. Then send 0x3C → count=1, rd_data=0x3C. Pulse clear_err → frame_err=0.
- Overrun: send 0x01..0x05 with no reads → count=4, overrun=1. Read 4 times → 0x01, 0x02, 0x03, 0x04.
- Boundary: FIFO full, assert rd_en on the push cycle of 0x06 → count stays 4, overrun=0, reads return 0x02..0x04 then 0x06.
- Parity (with UART_RX_PARITY_EN): send 0x07 with parity bit 0 → parity_err=1, no push. Send 0x07 with parity bit 1 → rd_data=0x07.
